// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the multi-cycle sequencer: state encodings and PC mux selects.
// No logic of its own; consumed by the sequencer top and its bench.
// Includes one helper that resolves a conditional-branch select against the branch outcome.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [1:0] PC_SEL_REG = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_J   = 2'b10;
    localparam logic [1:0] PC_SEL_INC = 2'b11;

    // An untaken conditional branch falls through to PC+4; every other select passes unchanged.
    function automatic logic [1:0] resolve_pc_sel(input logic [1:0] raw_sel, input logic taken);
        return ((raw_sel == PC_SEL_BR) && !taken) ? PC_SEL_INC : raw_sel;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle of the sequencer's memory handshakes, decoder inputs and datapath enables.
// Pure wiring, no latency.
// Requests are levels held until the matching ack; there is no other backpressure.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic             ir_we;
    logic             dec_gp_we;
    logic             dec_dm_we;
    logic             dec_is_load;
    logic [1:0]       dec_pc_sel;
    logic             bce_taken;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             gp_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             halt_req;
    logic             halted;
    logic             bus_err;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state;

    // Sequencer side.
    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, gp_we, pc_we, pc_sel,
               halted, bus_err, retired, state,
        input  imem_ack, dec_gp_we, dec_dm_we, dec_is_load, dec_pc_sel,
               bce_taken, dmem_ack, halt_req
    );

    // Datapath / memory / decoder side.
    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, gp_we, pc_we, pc_sel,
               halted, bus_err, retired, state,
        output imem_ack, dec_gp_we, dec_dm_we, dec_is_load, dec_pc_sel,
               bce_taken, dmem_ack, halt_req
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has waited for its ack and flags expiry at TIMEOUT-1.
// expired is combinational from the count register, valid in the same cycle.
// Holds its value when neither clr nor inc is asserted.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Wait counter: cleared outside waiting states, advances on each un-acked cycle.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = (cnt == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM sequencing fetch/decode/exec/mem/writeback for the MIPS datapath.
// CPI 4 for ALU/branch/jump, 5 plus memory wait cycles for lw/sw; ir_we follows imem_ack same cycle.
// Stalls in FETCH/MEM until ack; an ack overdue by TIMEOUT cycles parks the FSM in ERR until reset.
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_sequencer_if.master bus
);
    state_t           state_q;
    logic [CNT_W-1:0] retired_q;
    logic             bus_err_q;

    logic in_fetch;
    logic in_mem;
    logic timer_clr;
    logic timer_inc;
    logic timer_exp;

    assign in_fetch  = (state_q == ST_FETCH);
    assign in_mem    = (state_q == ST_MEM);
    // Clearing in every non-waiting state guarantees a zero count on entry to FETCH or MEM.
    assign timer_clr = !(in_fetch || in_mem);
    assign timer_inc = (in_fetch && !bus.imem_ack) || (in_mem && !bus.dmem_ack);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (timer_exp)
    );

    // State transitions, retired-instruction counter and sticky bus error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        state_q <= ST_DECODE;
                    end else if (timer_exp) begin
                        state_q   <= ST_ERR;
                        bus_err_q <= 1'b1;
                    end
                end
                ST_DECODE: state_q <= ST_EXEC;
                ST_EXEC: begin
                    state_q <= (bus.dec_dm_we || bus.dec_is_load) ? ST_MEM : ST_WB;
                end
                ST_MEM: begin
                    if (bus.dmem_ack) begin
                        state_q <= ST_WB;
                    end else if (timer_exp) begin
                        state_q   <= ST_ERR;
                        bus_err_q <= 1'b1;
                    end
                end
                ST_WB: begin
                    retired_q <= retired_q + CNT_W'(1);
                    state_q   <= bus.halt_req ? ST_HALT : ST_FETCH;
                end
                ST_HALT: begin
                    if (!bus.halt_req) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_ERR:  state_q <= ST_ERR;
                default: state_q <= ST_ERR;
            endcase
        end
    end

    // Phase-gated enables decoded from the state; everything reads as zero while reset is high
    // so an access in flight is abandoned without a partial write.
    always_comb begin
        bus.imem_req = 1'b0;
        bus.ir_we    = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.gp_we    = 1'b0;
        bus.pc_we    = 1'b0;
        bus.halted   = 1'b0;
        bus.pc_sel   = reset ? PC_SEL_REG : PC_SEL_INC;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ack;
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.dmem_we  = bus.dec_dm_we;
                end
                ST_WB: begin
                    bus.gp_we  = bus.dec_gp_we;
                    bus.pc_we  = 1'b1;
                    bus.pc_sel = resolve_pc_sel(bus.dec_pc_sel, bus.bce_taken);
                end
                ST_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.bus_err = bus_err_q && !reset;
    assign bus.retired = reset ? '0 : retired_q;
    assign bus.state   = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: ALU, lw, branch, halt, reset mid-sw and ack timeout.
// Inputs change 2ns after the rising edge; outputs are compared 1ns later, well before the next edge.
// Expected values are hand-derived constants.
module tb_multicycle_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();

    multicycle_sequencer #(
        .TIMEOUT (15),
        .CNT_W   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic set_dec(input logic gp, input logic dm, input logic ld,
                           input logic [1:0] sel, input logic taken);
        bus.dec_gp_we   = gp;
        bus.dec_dm_we   = dm;
        bus.dec_is_load = ld;
        bus.dec_pc_sel  = sel;
        bus.bce_taken   = taken;
    endtask

    // Zero-wait fetch from FETCH; returns in DECODE with inputs settled.
    task automatic fetch_now();
        bus.imem_ack = 1'b1;
        #1;
        nxt();
        bus.imem_ack = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        bus.halt_req = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        #3;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_state",    bus.state,    0);
        check("rst_retired",  bus.retired,  0);
        check("rst_bus_err",  bus.bus_err,  0);
        nxt();
        nxt();
        reset = 1'b0;
        #1;
        check("post_rst_state",    bus.state,    ST_FETCH);
        check("post_rst_imem_req", bus.imem_req, 1);

        // ALU op, zero-wait fetch.
        set_dec(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        bus.imem_ack = 1'b1;
        #1;
        check("alu_ir_we",       bus.ir_we, 1);
        check("alu_fetch_pc_we", bus.pc_we, 0);
        nxt();
        bus.imem_ack = 1'b0;
        #1;
        check("alu_decode_state", bus.state,    ST_DECODE);
        check("alu_decode_req",   bus.imem_req, 0);
        check("alu_decode_ir_we", bus.ir_we,    0);
        nxt();
        check("alu_exec_state", bus.state, ST_EXEC);
        check("alu_exec_gp_we", bus.gp_we, 0);
        nxt();
        check("alu_wb_state",   bus.state,   ST_WB);
        check("alu_wb_gp_we",   bus.gp_we,   1);
        check("alu_wb_pc_we",   bus.pc_we,   1);
        check("alu_wb_pc_sel",  bus.pc_sel,  2'b11);
        check("alu_wb_retired", bus.retired, 0);
        nxt();
        check("alu_done_state",   bus.state,   ST_FETCH);
        check("alu_done_retired", bus.retired, 1);
        check("alu_done_pc_we",   bus.pc_we,   0);

        // lw with dmem_ack in the third MEM cycle.
        set_dec(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
        fetch_now();
        nxt();
        check("lw_exec_state", bus.state, ST_EXEC);
        nxt();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                bus.dmem_ack = 1'b1;
                #1;
            end
            check("lw_mem_state",    bus.state,    ST_MEM);
            check("lw_mem_dmem_req", bus.dmem_req, 1);
            check("lw_mem_dmem_we",  bus.dmem_we,  0);
            check("lw_mem_gp_we",    bus.gp_we,    0);
            nxt();
        end
        bus.dmem_ack = 1'b0;
        #1;
        check("lw_wb_state",    bus.state,    ST_WB);
        check("lw_wb_dmem_req", bus.dmem_req, 0);
        check("lw_wb_gp_we",    bus.gp_we,    1);
        nxt();
        check("lw_done_retired", bus.retired, 2);

        // Branch: taken, then untaken, then a jump select in the same WB cycle.
        set_dec(1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        fetch_now();
        check("br_decode_pc_sel", bus.pc_sel, 2'b11);
        nxt();
        nxt();
        check("br_wb_state",       bus.state,  ST_WB);
        check("br_taken_pc_sel",   bus.pc_sel, 2'b01);
        check("br_wb_gp_we",       bus.gp_we,  0);
        bus.bce_taken = 1'b0;
        #1;
        check("br_untaken_pc_sel", bus.pc_sel, 2'b11);
        bus.dec_pc_sel = 2'b10;
        #1;
        check("jump_pc_sel",       bus.pc_sel, 2'b10);
        nxt();
        check("br_done_retired", bus.retired, 3);

        // Halt at the instruction boundary.
        set_dec(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        bus.halt_req = 1'b1;
        fetch_now();
        check("halt_ignored_in_decode", bus.state, ST_DECODE);
        nxt();
        nxt();
        check("halt_wb_state", bus.state, ST_WB);
        nxt();
        check("halt_state",    bus.state,    ST_HALT);
        check("halt_halted",   bus.halted,   1);
        check("halt_imem_req", bus.imem_req, 0);
        check("halt_dmem_req", bus.dmem_req, 0);
        check("halt_pc_we",    bus.pc_we,    0);
        check("halt_retired",  bus.retired,  4);
        nxt();
        check("halt_hold_state", bus.state, ST_HALT);
        bus.halt_req = 1'b0;
        #1;
        check("halt_still_halted", bus.halted, 1);
        nxt();
        check("unhalt_state",    bus.state,    ST_FETCH);
        check("unhalt_halted",   bus.halted,   0);
        check("unhalt_imem_req", bus.imem_req, 1);

        // Reset asserted while a sw waits in MEM.
        set_dec(1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
        fetch_now();
        nxt();
        nxt();
        check("sw_mem_state",    bus.state,    ST_MEM);
        check("sw_mem_dmem_req", bus.dmem_req, 1);
        check("sw_mem_dmem_we",  bus.dmem_we,  1);
        nxt();
        reset = 1'b1;
        #1;
        check("sw_rst_dmem_req", bus.dmem_req, 0);
        check("sw_rst_dmem_we",  bus.dmem_we,  0);
        check("sw_rst_gp_we",    bus.gp_we,    0);
        check("sw_rst_pc_we",    bus.pc_we,    0);
        nxt();
        reset = 1'b0;
        #1;
        check("sw_after_state",    bus.state,    ST_FETCH);
        check("sw_after_retired",  bus.retired,  0);
        check("sw_after_imem_req", bus.imem_req, 1);

        // Ack arriving in the 15th FETCH cycle still decodes; dmem_ack in FETCH is ignored.
        set_dec(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
        bus.dmem_ack = 1'b1;
        #1;
        for (int i = 0; i < 14; i++) begin
            check("late_wait_state", bus.state, ST_FETCH);
            nxt();
        end
        check("late_last_bus_err", bus.bus_err, 0);
        bus.imem_ack = 1'b1;
        #1;
        check("late_ir_we", bus.ir_we, 1);
        nxt();
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        #1;
        check("late_decode_state", bus.state,   ST_DECODE);
        check("late_bus_err",      bus.bus_err, 0);
        nxt();
        nxt();
        nxt();
        check("late_done_retired", bus.retired, 1);

        // No ack at all: ERR 15 cycles after FETCH entry, sticky until reset.
        repeat (14) nxt();
        check("to_last_fetch_state", bus.state,   ST_FETCH);
        check("to_last_bus_err",     bus.bus_err, 0);
        nxt();
        check("to_err_state",    bus.state,    ST_ERR);
        check("to_err_bus_err",  bus.bus_err,  1);
        check("to_err_imem_req", bus.imem_req, 0);
        bus.imem_ack = 1'b1;
        #1;
        check("to_err_ir_we", bus.ir_we, 0);
        repeat (3) nxt();
        check("to_sticky_state",   bus.state,   ST_ERR);
        check("to_sticky_bus_err", bus.bus_err, 1);
        check("to_frozen_retired", bus.retired, 1);
        bus.imem_ack = 1'b0;
        reset = 1'b1;
        nxt();
        reset = 1'b0;
        #1;
        check("err_clear_bus_err", bus.bus_err, 0);
        check("err_clear_state",   bus.state,   ST_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
